// File: rtl/ruperta_pkg.sv
// ruperta_pkg: shared ARM-subset encodings, flag bit indices and condition evaluation
package ruperta_pkg;
  typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_B = 2'b10, OP_NONE = 2'b11} op_e;
  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_e;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11} alu_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  function automatic logic cond_ex(cond_e c, logic [3:0] f);
    logic n, z, cf, v;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cf = f[FLAG_C];
    v  = f[FLAG_V];
    case (c)
      C_EQ: return z;
      C_NE: return !z;
      C_CS: return cf;
      C_CC: return !cf;
      C_MI: return n;
      C_PL: return !n;
      C_VS: return v;
      C_VC: return !v;
      C_HI: return cf && !z;
      C_LS: return !cf || z;
      C_GE: return n == v;
      C_LT: return n != v;
      C_GT: return !z && (n == v);
      C_LE: return z || (n != v);
      C_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/controller_if.sv
// controller_if: instruction/flag inputs and control outputs between datapath and controller
interface controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic        MemWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic        MemtoReg;
  logic        PCSrc;
  logic [1:0]  ALUControl;
  modport master (
    output Instr, ALUFlags,
    input  RegSrc, RegWrite, MemWrite, ImmSrc, ALUSrc, MemtoReg, PCSrc, ALUControl
  );
  modport slave (
    input  Instr, ALUFlags,
    output RegSrc, RegWrite, MemWrite, ImmSrc, ALUSrc, MemtoReg, PCSrc, ALUControl
  );
endinterface

// File: rtl/controller_condlogic.sv
// condlogic: NZCV flags register, condition evaluation and gating of write/branch enables
import ruperta_pkg::*;
module condlogic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write
);
  logic [3:0] flags;
  logic       ce;
  assign ce        = cond_ex(cond_e'(cond), flags);
  assign pc_src    = pcs && ce;
  assign reg_write = reg_w && ce && !no_write;
  assign mem_write = mem_w && ce;
  // instruction sees only flags registered by earlier instructions
  always_ff @(posedge clk or posedge reset)
    if (reset) flags <= '0;
    else begin
      if (flag_w[1] && ce) flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
      if (flag_w[0] && ce) flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
    end
endmodule

// File: rtl/controller.sv
// controller: ARM-subset main/ALU decoders driving condlogic; RUPERTA_CMP_EN adds CMP decode
import ruperta_pkg::*;
module controller (
  input logic         clk,
  input logic         reset,
  controller_if.slave bus
);
  op_e        op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       s, branch, ld, st, alu_op, reg_w, mem_w, pcs, no_write;
  logic [1:0] flag_w;
  alu_e       alu_ctl;
  assign op    = op_e'(bus.Instr[15:14]);
  assign funct = bus.Instr[13:8];
  assign cmd   = funct[4:1];
  assign s     = funct[0];
  always_comb begin
    branch       = op == OP_B;
    ld           = op == OP_MEM && funct[0];
    st           = op == OP_MEM && !funct[0];
    alu_op       = op == OP_DP;
    reg_w        = alu_op || ld;
    mem_w        = st;
    bus.ALUSrc   = alu_op ? funct[5] : (op == OP_MEM || branch);
    bus.ImmSrc   = op == OP_MEM ? 2'b01 : branch ? 2'b10 : 2'b00;
    bus.MemtoReg = ld;
    bus.RegSrc   = {st, branch};
    pcs          = branch || (reg_w && bus.Instr[3:0] == 4'hF);
  end
  always_comb begin
    alu_ctl  = !alu_op          ? ALU_ADD :
               cmd == 4'b0100   ? ALU_ADD :
               cmd == 4'b0010   ? ALU_SUB :
               cmd == 4'b0000   ? ALU_AND :
               cmd == 4'b1100   ? ALU_ORR : ALU_ADD;
    flag_w   = {alu_op && s, alu_op && s && (cmd == 4'b0100 || cmd == 4'b0010)};
    no_write = 1'b0;
`ifdef RUPERTA_CMP_EN
    if (alu_op && s && cmd == 4'b1010) begin
      alu_ctl  = ALU_SUB;
      flag_w   = 2'b11;
      no_write = 1'b1;
    end
`endif
  end
  assign bus.ALUControl = alu_ctl;
  condlogic u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (bus.Instr[19:16]),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .pc_src    (bus.PCSrc),
    .reg_write (bus.RegWrite),
    .mem_write (bus.MemWrite)
  );
endmodule

// File: tb/tb_controller.sv
// tb_controller: scoreboard bench; reference model predicts controls and tracks NZCV
module tb_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  controller_if bus ();
  controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  logic [3:0]  mflags = 4'b0;
  logic [10:0] exp_q[$];
  logic [1:0]  fw_q[$];
  logic [10:0] obs;
  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  // output word: {RegSrc, RegWrite, MemWrite, ImmSrc, ALUSrc, MemtoReg, PCSrc, ALUControl}
  function automatic logic [10:0] model(logic [19:0] i, logic [3:0] fl, output logic [1:0] fw_o);
    logic n, z, c, v, ce, rw, mw, asrc, m2r, br, nw;
    logic [1:0] rs, imm, ac, fw;
    logic [5:0] fn;
    logic [3:0] cmd;
    {n, z, c, v} = fl;
    fn  = i[13:8];
    cmd = fn[4:1];
    case (i[19:16])
      4'd0: ce = z;          4'd1: ce = !z;
      4'd2: ce = c;          4'd3: ce = !c;
      4'd4: ce = n;          4'd5: ce = !n;
      4'd6: ce = v;          4'd7: ce = !v;
      4'd8: ce = c & !z;     4'd9: ce = !c | z;
      4'd10: ce = n == v;    4'd11: ce = n != v;
      4'd12: ce = !z & (n == v);
      4'd13: ce = z | (n != v);
      4'd14: ce = 1'b1;
      default: ce = 1'b0;
    endcase
    {rs, rw, mw, imm, asrc, m2r, br, ac, fw, nw} = '0;
    case (i[15:14])
      2'b00: begin
        rw = 1; asrc = fn[5];
        case (cmd)
          4'b0010: ac = 2'b01;
          4'b0000: ac = 2'b10;
          4'b1100: ac = 2'b11;
          default: ac = 2'b00;
        endcase
        fw = {fn[0], fn[0] & (cmd == 4'b0100 || cmd == 4'b0010)};
`ifdef RUPERTA_CMP_EN
        if (cmd == 4'b1010 && fn[0]) begin ac = 2'b01; fw = 2'b11; nw = 1; end
`endif
      end
      2'b01: begin
        asrc = 1; imm = 2'b01;
        if (fn[0]) begin rw = 1; m2r = 1; end
        else begin mw = 1; rs = 2'b10; end
      end
      2'b10: begin br = 1; asrc = 1; imm = 2'b10; rs = 2'b01; end
      default: ;
    endcase
    fw_o = ce ? fw : 2'b00;
    return {rs, rw & ce & !nw, mw & ce, imm, asrc, m2r, (br | (rw & i[3:0] == 4'hF)) & ce, ac};
  endfunction
  task automatic step(logic [19:0] i, logic [3:0] af);
    logic [1:0] fw;
    bus.Instr = i;
    bus.ALUFlags = af;
    exp_q.push_back(model(i, mflags, fw));
    fw_q.push_back(fw);
    @(negedge clk);
    obs = {bus.RegSrc, bus.RegWrite, bus.MemWrite, bus.ImmSrc, bus.ALUSrc, bus.MemtoReg,
           bus.PCSrc, bus.ALUControl};
    if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
    else begin
      check($sformatf("ctl_%05h", i), {21'b0, obs}, {21'b0, exp_q.pop_front()});
      fw = fw_q.pop_front();
      if (fw[1]) mflags[3:2] = af[3:2];
      if (fw[0]) mflags[1:0] = af[1:0];
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.Instr = 20'h00000;
    bus.ALUFlags = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_eq_regwrite", bus.RegWrite, 0);
    bus.Instr = 20'h10000;
    #1 check("rst_ne_regwrite", bus.RegWrite, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(20'hE0900, 4'hF);
    bus.Instr = 20'h00000;
    #1 check("pre_rst_eq", bus.RegWrite, 1);
    reset = 1'b1;
    #1 check("async_rst_eq", bus.RegWrite, 0);
    bus.Instr = 20'hE0000;
    #1 check("rst_al_regwrite", bus.RegWrite, 1);
    reset = 1'b0;
    mflags = 4'b0;
    @(posedge clk);
    #1;
    step(20'hE0900, 4'b0100);
    step(20'h0A000, 4'b0000);
    check("beq_pcsrc", obs[2], 1);
    step(20'h1A000, 4'b0000);
    check("bne_pcsrc", obs[2], 0);
    step(20'hE0900, 4'b1100);
    step(20'hE0100, 4'b0011);
    step(20'h00000, 4'b0000);
    check("ands_z_cleared", obs[8], 0);
    step(20'h20000, 4'b0000);
    check("ands_c_kept", obs[8], 0);
    step(20'h00900, 4'hF);
    check("addeqs_regwrite", obs[8], 0);
    step(20'h40000, 4'b0000);
    check("addeqs_n_kept", obs[8], 0);
    step(20'h50000, 4'b0000);
    check("addeqs_pl", obs[8], 1);
    step(20'hE591F, 4'b0000);
    check("ldr_pc", {obs[2], obs[3], obs[6:5]}, 4'b1101);
    step(20'hE5810, 4'b0000);
    check("str", {obs[7], obs[10:9], obs[8]}, 4'b1100);
    step(20'hE1500, 4'b0100);
`ifdef RUPERTA_CMP_EN
    check("cmp_ctl", {obs[8], obs[1:0]}, 3'b001);
`else
    check("cmp_ctl", {obs[8], obs[1:0]}, 3'b100);
`endif
    step(20'h00000, 4'b0000);
    check("cmp_flags_eq", obs[8], 1);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 20'hFFFFF), 4'($urandom_range(0, 15)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
